// File: rtl/map_lfsr_gen_pkg.sv
// Shared types, default constants and the LFSR step function for map_lfsr_gen.
package map_lfsr_gen_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    // Widest LFSR the step function handles; callers zero-extend and truncate.
    localparam int unsigned LFSR_MAX_W = 32;

    localparam logic [7:0] DEF_TAPS = 8'hB8;
    localparam logic [7:0] DEF_SEED = 8'h00;

    // One XNOR-feedback shift of a w-bit LFSR held in the low bits of sr.
    function automatic logic [LFSR_MAX_W-1:0] lfsr_next(
        input logic [LFSR_MAX_W-1:0] sr,
        input logic [LFSR_MAX_W-1:0] taps,
        input int unsigned           w
    );
        logic                  fb;
        logic [LFSR_MAX_W-1:0] mask;
        fb   = ~^(sr & taps);
        mask = '0;
        for (int unsigned i = 0; i < LFSR_MAX_W; i++) begin
            if (i < w) mask[i] = 1'b1;
        end
        return {sr[LFSR_MAX_W-2:0], fb} & mask;
    endfunction

endpackage

// File: rtl/map_lfsr_gen_if.sv
// Host/consumer bundle for map_lfsr_gen: start/N/cont/abort in, dp valid/ready out.
interface map_lfsr_gen_if #(
    parameter int unsigned W = 8
);
    logic         start;
    logic [W:0]   N;
    logic         cont;
    logic         abort;
    logic [W:0]   dp;
    logic         dp_valid;
    logic         dp_ready;
    logic         done;
    logic         busy;
    logic [W-1:0] counter;
    logic [W-1:0] sr;

    modport master (
        output start, N, cont, abort, dp_ready,
        input  dp, dp_valid, done, busy, counter, sr
    );

    modport slave (
        input  start, N, cont, abort, dp_ready,
        output dp, dp_valid, done, busy, counter, sr
    );
endinterface

// File: rtl/map_lfsr_gen_start_sync.sv
// Start synchroniser and rising-edge detector for map_lfsr_gen.
module map_lfsr_gen_start_sync #(
    parameter bit SYNC_START = 1'b1
) (
    input  logic clock,
    input  logic reset,
    input  logic start,
    output logic start_rise
);
    logic s0;
    logic s1;
    logic primed;
    logic armed;

    // Sample start and arm the detector only after start has been seen low
    // following reset, so a start held high through reset cannot retrigger.
    always_ff @(posedge clock) begin
        if (reset) begin
            s0     <= 1'b0;
            s1     <= 1'b0;
            primed <= 1'b0;
            armed  <= 1'b0;
        end else begin
            s0     <= start;
            s1     <= s0;
            primed <= 1'b1;
            if (primed && !s0) armed <= 1'b1;
        end
    end

    assign start_rise = (SYNC_START) ? (armed & s0 & ~s1)
                                     : (armed & start & ~s0);
endmodule

// File: rtl/map_lfsr_gen.sv
// LFSR mapping engine: steps a W-bit XNOR LFSR K times and offers {sr, n0}.
module map_lfsr_gen
    import map_lfsr_gen_pkg::*;
#(
    parameter int unsigned   W          = 8,
    parameter logic [W-1:0]  TAPS       = W'(DEF_TAPS),
    parameter logic [W-1:0]  SEED       = W'(DEF_SEED),
    parameter bit            SYNC_START = 1'b1
) (
    input  logic           clock,
    input  logic           reset,
    map_lfsr_gen_if.slave  bus
);
    state_t       state, state_n;
    logic [W-1:0] counter, counter_n;
    logic [W-1:0] sr, sr_n;
    logic [W-1:0] sr_step;
    logic [W-1:0] n_reg, n_reg_n;
    logic         n0, n0_n;
    logic         cont_r, cont_n;
    logic [W:0]   dp_r, dp_n;
    logic         dp_valid_r, dp_valid_n;
    logic         done_r, done_n;
    logic         busy_r, busy_n;
    logic         start_rise;

    map_lfsr_gen_start_sync #(
        .SYNC_START (SYNC_START)
    ) u_start_sync (
        .clock      (clock),
        .reset      (reset),
        .start      (bus.start),
        .start_rise (start_rise)
    );

    assign sr_step = W'(lfsr_next(LFSR_MAX_W'(sr), LFSR_MAX_W'(TAPS), W));

    // Register all state; reset dominates everything.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            counter    <= '0;
            sr         <= SEED;
            n_reg      <= '0;
            n0         <= 1'b0;
            cont_r     <= 1'b0;
            dp_r       <= '0;
            dp_valid_r <= 1'b0;
            done_r     <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            state      <= state_n;
            counter    <= counter_n;
            sr         <= sr_n;
            n_reg      <= n_reg_n;
            n0         <= n0_n;
            cont_r     <= cont_n;
            dp_r       <= dp_n;
            dp_valid_r <= dp_valid_n;
            done_r     <= done_n;
            busy_r     <= busy_n;
        end
    end

    // Next-state and datapath decode; abort outranks every non-IDLE action.
    always_comb begin
        state_n    = state;
        counter_n  = counter;
        sr_n       = sr;
        n_reg_n    = n_reg;
        n0_n       = n0;
        cont_n     = cont_r;
        dp_n       = dp_r;
        dp_valid_n = dp_valid_r;
        done_n     = done_r;

        if (bus.abort && (state != IDLE)) begin
            state_n    = IDLE;
            dp_valid_n = 1'b0;
            done_n     = 1'b0;
            cont_n     = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_rise) begin
                        counter_n = bus.N[W:1];
                        n_reg_n   = bus.N[W:1];
                        n0_n      = bus.N[0];
                        cont_n    = bus.cont;
                        sr_n      = SEED;
                        done_n    = 1'b0;
                        state_n   = RUN;
                    end
                end
                RUN: begin
                    if (counter != '0) begin
                        sr_n      = sr_step;
                        counter_n = counter - W'(1);
                    end else begin
                        dp_n       = {sr, n0};
                        dp_valid_n = 1'b1;
                        done_n     = 1'b1;
                        state_n    = HOLD;
                    end
                end
                HOLD: begin
                    if (dp_valid_r && bus.dp_ready) begin
                        dp_valid_n = 1'b0;
                        if (cont_r) begin
                            counter_n = n_reg;
                            state_n   = RUN;
                        end else begin
                            state_n   = IDLE;
                        end
                    end
                end
                default: state_n = IDLE;
            endcase
        end

        busy_n = (state_n != IDLE);
    end

    assign bus.dp       = dp_r;
    assign bus.dp_valid = dp_valid_r;
    assign bus.done     = done_r;
    assign bus.busy     = busy_r;
    assign bus.counter  = counter;
    assign bus.sr       = sr;
endmodule

// File: tb/tb_map_lfsr_gen.sv
// Directed bench for map_lfsr_gen (W=8, TAPS=B8, SEED=0, SYNC_START=1).
// Inputs change and outputs are sampled on the falling clock edge.
// Cycle index i counts falling edges after start is first driven high:
// start sampled at rising edge 0, accept at edge 1, K steps, capture at
// edge K+2, so dp_valid is first seen at falling edge i = K+3.
module tb_map_lfsr_gen;
    logic clock = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    always #5 clock = ~clock;

    map_lfsr_gen_if #(.W(8)) bus();

    map_lfsr_gen #(
        .W          (8),
        .TAPS       (8'hB8),
        .SEED       (8'h00),
        .SYNC_START (1'b1)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish (time %0t, required earlier)", $time);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic test_reset();
        reset = 1'b1; bus.start = 1'b0; bus.N = '0; bus.cont = 1'b0;
        bus.abort = 1'b0; bus.dp_ready = 1'b1;
        idle(3);
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        checks++; if (bus.dp_valid !== 1'b0) begin errors++; $display("FAIL reset_dp_valid: got %b want 0", bus.dp_valid); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", bus.done); end
        checks++; if (bus.dp !== 9'h000) begin errors++; $display("FAIL reset_dp: got %h want 000", bus.dp); end
        checks++; if (bus.sr !== 8'h00) begin errors++; $display("FAIL reset_sr: got %h want 00", bus.sr); end
        checks++; if (bus.counter !== 8'h00) begin errors++; $display("FAIL reset_counter: got %h want 00", bus.counter); end
        reset = 1'b0;
        idle(3);
    endtask

    task automatic test_basic();
        int n = 0;
        bus.N = 9'd9; bus.start = 1'b1;
        for (int i = 1; i <= 40 && n == 0; i++) begin
            tick();
            if (i == 3) bus.start = 1'b0;
            if (bus.dp_valid === 1'b1) n = i;
        end
        checks++; if (n !== 7) begin errors++; $display("FAIL basic_latency: got %0d want 7", n); end
        checks++; if (bus.dp !== 9'h01F) begin errors++; $display("FAIL basic_dp: got %h want 01f", bus.dp); end
        checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL basic_done: got %b want 1", bus.done); end
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL basic_busy_hold: got %b want 1", bus.busy); end
        tick();
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL basic_busy_after: got %b want 0", bus.busy); end
        checks++; if (bus.dp_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_after: got %b want 0", bus.dp_valid); end
        checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL basic_done_after: got %b want 1", bus.done); end
        idle(3);
    endtask

    task automatic test_sr_sequence();
        logic [7:0] exp_sr [6] = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1E, 8'h3D};
        int n = 0;
        bus.N = 9'd12; bus.start = 1'b1;
        for (int i = 1; i <= 40 && n == 0; i++) begin
            tick();
            if (i == 3) bus.start = 1'b0;
            if (i >= 3 && i <= 8) begin
                checks++;
                if (bus.sr !== exp_sr[i-3]) begin
                    errors++; $display("FAIL seq_sr_step%0d: got %h want %h", i-2, bus.sr, exp_sr[i-3]);
                end
            end
            if (bus.dp_valid === 1'b1) n = i;
        end
        checks++; if (n !== 9) begin errors++; $display("FAIL seq_latency: got %0d want 9", n); end
        checks++; if (bus.dp !== 9'h07A) begin errors++; $display("FAIL seq_dp: got %h want 07a", bus.dp); end
        idle(4);
    endtask

    task automatic test_k0();
        int n = 0;
        bus.N = 9'd1; bus.start = 1'b1;
        for (int i = 1; i <= 40 && n == 0; i++) begin
            tick();
            if (i == 3) bus.start = 1'b0;
            if (bus.dp_valid === 1'b1) n = i;
        end
        checks++; if (n !== 3) begin errors++; $display("FAIL k0_latency: got %0d want 3", n); end
        checks++; if (bus.dp !== 9'h001) begin errors++; $display("FAIL k0_dp: got %h want 001", bus.dp); end
        idle(4);
    endtask

    task automatic test_kmax();
        int n = 0;
        int bad = 0;
        bus.N = 9'd510; bus.start = 1'b1;
        for (int i = 1; i <= 400 && n == 0; i++) begin
            tick();
            if (i == 3) bus.start = 1'b0;
            if (i >= 2 && i <= 257 && bus.counter !== 8'(257 - i)) bad++;
            if (bus.dp_valid === 1'b1) n = i;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL kmax_counter_walk: got %0d bad cycles want 0", bad); end
        checks++; if (n !== 258) begin errors++; $display("FAIL kmax_latency: got %0d want 258", n); end
        checks++; if (bus.dp[0] !== 1'b0) begin errors++; $display("FAIL kmax_n0: got %b want 0", bus.dp[0]); end
        checks++; if (bus.dp[8:1] !== bus.sr) begin errors++; $display("FAIL kmax_dp_sr: got %h want %h", bus.dp[8:1], bus.sr); end
        idle(4);
    endtask

    task automatic test_stall();
        int n = 0;
        int bad = 0;
        int extra = 0;
        bus.dp_ready = 1'b0;
        bus.N = 9'd9; bus.start = 1'b1;
        for (int i = 1; i <= 40 && n == 0; i++) begin
            tick();
            if (i == 3) bus.start = 1'b0;
            if (bus.dp_valid === 1'b1) n = i;
        end
        checks++; if (n !== 7) begin errors++; $display("FAIL stall_latency: got %0d want 7", n); end
        for (int j = 1; j <= 10; j++) begin
            tick();
            if (j == 2) bus.start = 1'b1;
            if (j == 5) bus.start = 1'b0;
            if (bus.dp !== 9'h01F || bus.dp_valid !== 1'b1) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL stall_stable: got %0d unstable cycles want 0", bad); end
        bus.dp_ready = 1'b1;
        tick();
        checks++; if (bus.dp_valid !== 1'b0) begin errors++; $display("FAIL stall_release_valid: got %b want 0", bus.dp_valid); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL stall_release_busy: got %b want 0", bus.busy); end
        for (int j = 0; j < 20; j++) begin
            tick();
            if (bus.dp_valid !== 1'b0 || bus.busy !== 1'b0) extra++;
        end
        checks++; if (extra !== 0) begin errors++; $display("FAIL stall_no_second: got %0d active cycles want 0", extra); end
    endtask

    task automatic test_cont_abort();
        logic [8:0] res [3];
        int         at  [3];
        logic [8:0] exp_res [3] = '{9'h006, 9'h01E, 9'h07A};
        int         exp_at  [3] = '{5, 9, 13};
        int         cnt = 0;
        int         extra = 0;
        bus.cont = 1'b1; bus.N = 9'd4; bus.start = 1'b1;
        for (int i = 0; i < 3; i++) begin res[i] = '0; at[i] = 0; end
        for (int i = 1; i <= 60 && cnt < 3; i++) begin
            tick();
            if (i == 3) bus.start = 1'b0;
            if (bus.dp_valid === 1'b1) begin res[cnt] = bus.dp; at[cnt] = i; cnt++; end
        end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (res[k] !== exp_res[k] || at[k] !== exp_at[k]) begin
                errors++;
                $display("FAIL cont_result%0d: got %h at %0d want %h at %0d", k, res[k], at[k], exp_res[k], exp_at[k]);
            end
        end
        bus.cont = 1'b0;
        tick();
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", bus.busy); end
        checks++; if (bus.dp_valid !== 1'b0) begin errors++; $display("FAIL abort_valid: got %b want 0", bus.dp_valid); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL abort_done: got %b want 0", bus.done); end
        checks++; if (bus.dp !== 9'h07A) begin errors++; $display("FAIL abort_dp_kept: got %h want 07a", bus.dp); end
        checks++; if (bus.sr !== 8'h3D) begin errors++; $display("FAIL abort_sr_frozen: got %h want 3d", bus.sr); end
        for (int j = 0; j < 20; j++) begin
            tick();
            if (bus.dp_valid !== 1'b0 || bus.busy !== 1'b0) extra++;
        end
        checks++; if (extra !== 0) begin errors++; $display("FAIL abort_no_more: got %0d active cycles want 0", extra); end
    endtask

    task automatic test_reset_mid_run();
        int extra = 0;
        bus.N = 9'd510; bus.start = 1'b1;
        idle(10);
        reset = 1'b1;
        tick();
        checks++;
        if (bus.busy !== 1'b0 || bus.dp_valid !== 1'b0 || bus.done !== 1'b0 ||
            bus.dp !== 9'h000 || bus.sr !== 8'h00 || bus.counter !== 8'h00) begin
            errors++;
            $display("FAIL midreset_outputs: got busy=%b valid=%b done=%b dp=%h sr=%h cnt=%h want all zero",
                     bus.busy, bus.dp_valid, bus.done, bus.dp, bus.sr, bus.counter);
        end
        reset = 1'b0;
        for (int j = 0; j < 20; j++) begin
            tick();
            if (bus.busy !== 1'b0) extra++;
        end
        checks++; if (extra !== 0) begin errors++; $display("FAIL midreset_no_restart: got %0d busy cycles want 0", extra); end
        bus.start = 1'b0;
        idle(3);
        bus.start = 1'b1;
        idle(3);
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL midreset_rearm: got busy=%b want 1", bus.busy); end
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0; bus.start = 1'b0;
        idle(3);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_sr_sequence();
        test_k0();
        test_kmax();
        test_stall();
        test_cont_abort();
        test_reset_mid_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
